// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - Ethernet II transmit framer feeding the RMII serializer
//
// Takes payload bytes (starting at the destination MAC) and emits a full frame:
// 7x 0x55 preamble, 0xD5 SFD, payload, zero pad up to MIN_FRAME, CRC-32 FCS
// (LSB first), then IFG_BYTES byte times of silence. Each output byte is held
// for four refclk cycles because the serializer takes 2 bits per cycle.
//
// Ports:
//   refclk, sresetn          clock, synchronous active-low reset
//   in_tvalid/in_tready      payload handshake; in_tready pulses once per byte slot
//   in_tlast, in_tdata       last-byte flag, payload byte
//   out_tvalid               frame in progress (serializer tx_en)
//   out_tlast                high during all four cycles of the final FCS byte
//   out_tdata                current byte, changes only on phase 0
//   underrun                 one-cycle pulse when a payload request finds no data
//   busy                     high whenever the framer is not idle
module eth_tx_framer #(
   parameter int MIN_FRAME = 60,
   parameter int IFG_BYTES = 12
) (
   input  logic       refclk,
   input  logic       sresetn,
   input  logic       in_tvalid,
   output logic       in_tready,
   input  logic       in_tlast,
   input  logic [7:0] in_tdata,
   output logic       out_tvalid,
   output logic       out_tlast,
   output logic [7:0] out_tdata,
   output logic       underrun,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
   } state_t;

   localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);
   // With a zero gap the frame end goes straight back to idle.
   localparam state_t      AFTER_FRAME = (IFG_BYTES > 0) ? S_IFG : S_IDLE;

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [15:0] tmr_q, tmr_d;      // preamble slot, FCS slot or IFG cycle index
   logic [15:0] cnt_q, cnt_d;      // bytes sent from destination MAC, saturating
   logic [31:0] crc_q, crc_d;
   logic [7:0]  data_q, data_d;
   logic        last_q, last_d;    // byte on the wire is the final payload byte

   logic        req;
   logic [15:0] cnt_inc;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] x;
      x = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) begin
         x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      end
      return x;
   endfunction

   // Payload is requested on the last cycle of a slot so the byte is on the
   // wire from the very next phase 0.
   assign req = (phase_q == 2'd3) &&
                ((state_q == S_SFD) || ((state_q == S_DATA) && !last_q));

   assign cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign in_tready  = req || (state_q == S_DRAIN);
   assign underrun   = req && !in_tvalid;
   assign out_tvalid = (state_q == S_PRE) || (state_q == S_SFD) || (state_q == S_DATA) ||
                       (state_q == S_PAD) || (state_q == S_FCS);
   assign out_tlast  = (state_q == S_FCS) && (tmr_q == 16'd3);
   assign out_tdata  = data_q;
   assign busy       = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      phase_d = out_tvalid ? phase_q + 2'd1 : 2'd0;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      data_d  = data_q;
      last_d  = last_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_tvalid) begin
               state_d = S_PRE;
               data_d  = 8'h55;
               tmr_d   = 16'd0;
               cnt_d   = 16'd0;
               crc_d   = 32'hFFFFFFFF;
               last_d  = 1'b0;
            end
         end

         S_PRE: begin
            if (phase_q == 2'd3) begin
               if (tmr_q == 16'd6) begin
                  state_d = S_SFD;
                  data_d  = 8'hD5;
               end else begin
                  tmr_d = tmr_q + 16'd1;
               end
            end
         end

         S_SFD, S_DATA: begin
            if ((state_q == S_DATA) && (phase_q == 2'd0)) begin
               crc_d = crc_byte(crc_q, data_q);
            end
            if (req) begin
               if (in_tvalid) begin
                  state_d = S_DATA;
                  data_d  = in_tdata;
                  last_d  = in_tlast;
                  cnt_d   = cnt_inc;
               end else begin
                  // Phase 3 wraps to 0, so tx_en drops on a slot boundary.
                  state_d = S_DRAIN;
                  data_d  = 8'h00;
               end
            end else if (phase_q == 2'd3) begin
               // End of the slot carrying the final payload byte.
               if (cnt_q < MIN_LEN) begin
                  state_d = S_PAD;
                  data_d  = 8'h00;
                  cnt_d   = cnt_inc;
               end else begin
                  state_d = S_FCS;
                  data_d  = ~crc_q[7:0];
                  crc_d   = crc_q >> 8;
                  tmr_d   = 16'd0;
               end
            end
         end

         S_PAD: begin
            if (phase_q == 2'd0) begin
               crc_d = crc_byte(crc_q, data_q);
            end else if (phase_q == 2'd3) begin
               if (cnt_q < MIN_LEN) begin
                  cnt_d = cnt_inc;
               end else begin
                  state_d = S_FCS;
                  data_d  = ~crc_q[7:0];
                  crc_d   = crc_q >> 8;
                  tmr_d   = 16'd0;
               end
            end
         end

         S_FCS: begin
            // The CRC register is shifted down one byte per FCS slot.
            if (phase_q == 2'd3) begin
               if (tmr_q == 16'd3) begin
                  state_d = AFTER_FRAME;
                  data_d  = 8'h00;
                  tmr_d   = 16'd0;
               end else begin
                  tmr_d  = tmr_q + 16'd1;
                  data_d = ~crc_q[7:0];
                  crc_d  = crc_q >> 8;
               end
            end
         end

         S_DRAIN: begin
            if (in_tvalid && in_tlast) begin
               state_d = AFTER_FRAME;
               tmr_d   = 16'd0;
            end
         end

         S_IFG: begin
            if (tmr_q == IFG_LAST) begin
               state_d = S_IDLE;
               tmr_d   = 16'd0;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge refclk) begin
      if (!sresetn) begin
         state_q <= S_IDLE;
         phase_q <= 2'd0;
         tmr_q   <= 16'd0;
         cnt_q   <= 16'd0;
         crc_q   <= 32'hFFFFFFFF;
         data_q  <= 8'h00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - scoreboard bench for eth_tx_framer
module tb_eth_tx_framer;

   logic refclk = 1'b0;
   always #5 refclk = ~refclk;

   logic       sresetn;
   logic       sel;         // 0: dut0 (MIN_FRAME=0), 1: dut1 (defaults)
   logic       in_tvalid, in_tlast;
   logic [7:0] in_tdata;

   logic       iv0, iv1;
   logic       v0, l0, r0, u0, b0, v1, l1, r1, u1, b1;
   logic [7:0] d0, d1;
   logic       mv, ml, mr, mu, mb;
   logic [7:0] md;

   assign iv0 = in_tvalid && !sel;
   assign iv1 = in_tvalid && sel;
   assign mv  = sel ? v1 : v0;
   assign ml  = sel ? l1 : l0;
   assign mr  = sel ? r1 : r0;
   assign mu  = sel ? u1 : u0;
   assign mb  = sel ? b1 : b0;
   assign md  = sel ? d1 : d0;

   eth_tx_framer #(.MIN_FRAME(0), .IFG_BYTES(12)) dut0 (
      .refclk(refclk), .sresetn(sresetn),
      .in_tvalid(iv0), .in_tready(r0), .in_tlast(in_tlast), .in_tdata(in_tdata),
      .out_tvalid(v0), .out_tlast(l0), .out_tdata(d0), .underrun(u0), .busy(b0)
   );

   eth_tx_framer dut1 (
      .refclk(refclk), .sresetn(sresetn),
      .in_tvalid(iv1), .in_tready(r1), .in_tlast(in_tlast), .in_tdata(in_tdata),
      .out_tvalid(v1), .out_tlast(l1), .out_tdata(d1), .underrun(u1), .busy(b1)
   );

   typedef struct {
      logic [7:0] d;
      bit         last;
   } exp_t;

   exp_t       exp_q[$];
   int         len_q[$];
   int         rise_cyc[$];
   int         fall_cyc[$];
   int         rdy_log[$];
   logic [7:0] pay_q[$];
   int         plen_q[$];
   logic [7:0] buf_b[0:255];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   always @(posedge refclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] x;
      x = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      return x;
   endfunction

   task automatic push_byte(input logic [7:0] d, input bit l);
      exp_t e;
      e.d = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic push_pre();
      for (int i = 0; i < 7; i++) push_byte(8'h55, 1'b0);
      push_byte(8'hD5, 1'b0);
   endtask

   // Expected frame for buf_b[0..n-1], padded to minf, with reference FCS.
   task automatic queue_frame(input int n, input int minf);
      logic [31:0] c;
      logic [7:0]  b;
      int          p;
      p = (n < minf) ? minf : n;
      c = 32'hFFFFFFFF;
      push_pre();
      for (int i = 0; i < p; i++) begin
         b = (i < n) ? buf_b[i] : 8'h00;
         c = ref_crc(c, b);
         push_byte(b, 1'b0);
         if (i < n) pay_q.push_back(b);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) push_byte(c[8*i +: 8], i == 3);
      len_q.push_back(4 * (8 + p + 4));
      plen_q.push_back(n);
   endtask

   // Feed every queued frame, holding in_tvalid high between frames.
   task automatic drive(input bit mark_last);
      int len;
      int g;
      while (plen_q.size() > 0) begin
         len = plen_q.pop_front();
         for (int i = 0; i < len; i++) begin
            in_tdata  = pay_q.pop_front();
            in_tlast  = mark_last && (i == len - 1);
            in_tvalid = 1'b1;
            g = 0;
            @(negedge refclk);
            while (!mr && g < 2000) begin
               @(negedge refclk);
               g++;
            end
            if (!mr) begin
               chk("ready_timeout", mr, 1);
               in_tvalid = 1'b0;
               return;
            end
            @(posedge refclk);
            #1;
         end
      end
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
   endtask

   task automatic wait_falls(input int n);
      int g;
      g = 0;
      while (fall_cyc.size() < n && g < 4000) begin
         @(negedge refclk);
         g++;
      end
      if (fall_cyc.size() < n) chk("frame_timeout", fall_cyc.size(), n);
   endtask

   // Monitor: pops one expected byte per slot, checks hold, tlast, ready slot
   // position and total tx_en length of each frame.
   int         vcnt = 0;
   int         rdy_n = 0;
   bit         pv = 1'b0;
   logic [7:0] cur_d = 8'h00;
   bit         cur_l = 1'b0;
   exp_t       cur_e;

   always @(negedge refclk) begin
      if (!mon_en) begin
         vcnt = 0;
         pv   = 1'b0;
      end else begin
         if (mv) begin
            if (vcnt == 0) begin
               rise_cyc.push_back(cyc);
               rdy_n = 0;
            end
            if (vcnt % 4 == 0) begin
               chk("exp_avail", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  cur_e = exp_q.pop_front();
                  cur_d = cur_e.d;
                  cur_l = cur_e.last;
                  chk("byte", md, cur_d);
               end
            end else begin
               chk("hold", md, cur_d);
            end
            chk("tlast", ml, cur_l);
            if (mr) begin
               chk("ready_slot", (vcnt % 4 == 3) && (vcnt >= 31), 1);
               rdy_n++;
            end
            vcnt++;
         end else if (pv) begin
            fall_cyc.push_back(cyc);
            rdy_log.push_back(rdy_n);
            chk("len_avail", len_q.size() > 0, 1);
            if (len_q.size() > 0) chk("frame_len", vcnt, len_q.pop_front());
            vcnt = 0;
         end
         pv = mv;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int nf;
      int n;
      int g;

      sresetn   = 1'b0;
      sel       = 1'b0;
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      in_tdata  = 8'h00;

      // Reset with random inputs on both instances.
      for (int i = 0; i < 10; i++) begin
         @(posedge refclk);
         #1;
         sel       = 1'($urandom);
         in_tvalid = 1'($urandom);
         in_tlast  = 1'($urandom);
         in_tdata  = 8'($urandom);
         @(negedge refclk);
         chk("reset_outputs", {v0, l0, d0, r0, u0, b0, v1, l1, d1, r1, u1, b1}, 0);
      end
      @(posedge refclk);
      #1;
      sel       = 1'b0;
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      sresetn   = 1'b1;
      mon_en    = 1'b1;
      repeat (2) @(posedge refclk);
      #1;

      // MIN_FRAME=0, "123456789": known FCS 26 39 F4 CB.
      push_pre();
      for (int i = 0; i < 9; i++) begin
         pay_q.push_back(8'h31 + 8'(i));
         push_byte(8'h31 + 8'(i), 1'b0);
      end
      push_byte(8'h26, 1'b0);
      push_byte(8'h39, 1'b0);
      push_byte(8'hF4, 1'b0);
      push_byte(8'hCB, 1'b1);
      len_q.push_back(84);
      plen_q.push_back(9);
      drive(1'b1);
      wait_falls(1);
      if (rdy_log.size() > 0) chk("ready_count", rdy_log[0], 9);

      // Defaults, 1-byte payload padded to 60.
      repeat (60) @(posedge refclk);
      #1;
      sel = 1'b1;
      buf_b[0] = 8'hAB;
      queue_frame(1, 60);
      drive(1'b1);
      wait_falls(2);

      // Back-to-back 64-byte frames with in_tvalid held high.
      nf = fall_cyc.size();
      for (int i = 0; i < 64; i++) buf_b[i] = 8'(i * 7 + 3);
      queue_frame(64, 60);
      for (int i = 0; i < 64; i++) buf_b[i] = 8'(i) ^ 8'h5A;
      queue_frame(64, 60);
      drive(1'b1);
      wait_falls(nf + 2);
      if (rise_cyc.size() > nf + 1) chk("b2b_gap", rise_cyc[nf + 1] - fall_cyc[nf], 49);

      // Underrun at the 5th payload request.
      push_pre();
      for (int i = 0; i < 4; i++) begin
         pay_q.push_back(8'hC0 + 8'(i));
         push_byte(8'hC0 + 8'(i), 1'b0);
      end
      len_q.push_back(48);
      plen_q.push_back(4);
      drive(1'b0);
      g = 0;
      @(negedge refclk);
      while (!mr && g < 100) begin
         @(negedge refclk);
         g++;
      end
      chk("underrun_pulse", mu, 1);
      @(negedge refclk);
      chk("underrun_valid_drop", mv, 0);
      chk("underrun_one_cycle", mu, 0);
      chk("drain_ready", mr, 1);
      for (int i = 0; i < 3; i++) pay_q.push_back(8'hE0 + 8'(i));
      plen_q.push_back(3);
      @(posedge refclk);
      #1;
      drive(1'b1);
      n = 0;
      @(negedge refclk);
      while (mb && n < 200) begin
         n++;
         @(negedge refclk);
      end
      chk("underrun_gap", n, 48);

      // Reset mid-DATA, then a clean padded frame.
      mon_en    = 1'b0;
      in_tvalid = 1'b1;
      in_tdata  = 8'h11;
      in_tlast  = 1'b0;
      repeat (45) @(posedge refclk);
      #1;
      chk("pre_reset_active", mv, 1);
      sresetn   = 1'b0;
      in_tvalid = 1'b0;
      @(posedge refclk);
      #1;
      chk("midreset_outputs", {mv, ml, md, mr, mu, mb}, 0);
      @(posedge refclk);
      #1;
      sresetn = 1'b1;
      @(posedge refclk);
      #1;
      mon_en = 1'b1;
      nf = fall_cyc.size();
      for (int i = 0; i < 5; i++) buf_b[i] = 8'hA0 + 8'(i);
      queue_frame(5, 60);
      drive(1'b1);
      wait_falls(nf + 1);

      repeat (4) @(negedge refclk);
      chk("exp_queue_empty", exp_q.size(), 0);
      chk("len_queue_empty", len_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
